// File: rtl/risc_datapath_if.sv
// risc_datapath_if: sequencer/memory-facing signal bundle of the RISC datapath (strobes, selects, memory bus, status); carry exists only with RISC_DP_CARRY_EN
interface risc_datapath_if #(parameter int WORD_W = 8);
  logic L_R0, L_R1, L_R2, L_R3, L_PC, Inc_PC, L_IR, L_ADD_R, L_R_Y, L_R_Z, write;
  logic [2:0] Sel_Bus1;
  logic [1:0] Sel_Bus2;
  logic [WORD_W-1:0] mem_rdata, mem_addr, mem_wdata;
  logic [7:0] instruction;
  logic zero, mem_write;
`ifdef RISC_DP_CARRY_EN
  logic carry;
  modport master(output L_R0, L_R1, L_R2, L_R3, L_PC, Inc_PC, L_IR, L_ADD_R, L_R_Y, L_R_Z, write, Sel_Bus1, Sel_Bus2, mem_rdata,
                 input instruction, zero, mem_addr, mem_wdata, mem_write, carry);
  modport slave(input L_R0, L_R1, L_R2, L_R3, L_PC, Inc_PC, L_IR, L_ADD_R, L_R_Y, L_R_Z, write, Sel_Bus1, Sel_Bus2, mem_rdata,
                output instruction, zero, mem_addr, mem_wdata, mem_write, carry);
`else
  modport master(output L_R0, L_R1, L_R2, L_R3, L_PC, Inc_PC, L_IR, L_ADD_R, L_R_Y, L_R_Z, write, Sel_Bus1, Sel_Bus2, mem_rdata,
                 input instruction, zero, mem_addr, mem_wdata, mem_write);
  modport slave(input L_R0, L_R1, L_R2, L_R3, L_PC, Inc_PC, L_IR, L_ADD_R, L_R_Y, L_R_Z, write, Sel_Bus1, Sel_Bus2, mem_rdata,
                output instruction, zero, mem_addr, mem_wdata, mem_write);
`endif
endinterface

// File: rtl/risc_datapath.sv
// risc_datapath: 8-bit RISC datapath (R0-R3, PC, IR, ADD_R, Y, Z, ALU, Bus1/Bus2 muxes); ports nclk, rst (sync, active-high), bus (risc_datapath_if.slave: strobes/selects/mem_rdata in; instruction, zero, mem_addr, mem_wdata, mem_write out); define RISC_DP_CARRY_EN for carry flag C on bus.carry
module risc_datapath #(parameter int WORD_W = 8) (
  input logic nclk,
  input logic rst,
  risc_datapath_if.slave bus
);
  logic [WORD_W-1:0] r [4];
  logic [WORD_W-1:0] pc, ir, add_r, y, bus1, bus2, alu_out, sum, dif;
  logic [3:0] op, ld_r;
  logic z;
`ifdef RISC_DP_CARRY_EN
  logic add_c, sub_c, alu_c, c;
  assign {add_c, sum} = {1'b0, y} + {1'b0, bus1};
  // SUB computes b-a; the extra bit is the borrow, set exactly when a > b
  assign {sub_c, dif} = {1'b0, bus1} - {1'b0, y};
  assign alu_c = op == 4'd1 ? add_c : op == 4'd2 ? sub_c : 1'b0;
  assign bus.carry = c;
`else
  assign sum = y + bus1;
  assign dif = bus1 - y;
`endif
  assign op = ir[7:4];
  assign ld_r = {bus.L_R3, bus.L_R2, bus.L_R1, bus.L_R0};
  always_comb begin
    bus1 = bus.Sel_Bus1[2] ? (bus.Sel_Bus1[1:0] == 2'b00 ? pc : '0) : r[bus.Sel_Bus1[1:0]];
    alu_out = op == 4'd1 ? sum : op == 4'd2 ? dif : op == 4'd3 ? (y & bus1) : op == 4'd4 ? ~bus1 : '0;
    bus2 = bus.Sel_Bus2 == 2'd0 ? alu_out : bus.Sel_Bus2 == 2'd1 ? bus1 : bus.Sel_Bus2 == 2'd2 ? bus.mem_rdata : '0;
  end
  assign bus.instruction = ir[7:0];
  assign bus.zero = z;
  assign bus.mem_addr = add_r;
  assign bus.mem_wdata = bus1;
  assign bus.mem_write = bus.write;
  always_ff @(posedge nclk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
      pc <= '0;
      ir <= '0;
      add_r <= '0;
      y <= '0;
      z <= 1'b0;
`ifdef RISC_DP_CARRY_EN
      c <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < 4; i++) if (ld_r[i]) r[i] <= bus2;
      pc <= bus.L_PC ? bus2 : bus.Inc_PC ? pc + WORD_W'(1) : pc;
      if (bus.L_IR) ir <= bus2;
      if (bus.L_ADD_R) add_r <= bus2;
      if (bus.L_R_Y) y <= bus2;
      if (bus.L_R_Z) z <= alu_out == '0;
`ifdef RISC_DP_CARRY_EN
      if (bus.L_R_Z) c <= alu_c;
`endif
    end
  end
endmodule
